// File: rtl/reg_wr_arbiter_if.sv
// Bus between the register-file write requesters and the write-port arbiter.
// The master side drives requests; the slave side (the arbiter) returns the grant.
interface reg_wr_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Round-robin owner selection for the single register-file write port.
// Each tenure is capped at MAX_HOLD cycles, and one idle cycle always separates two owners.
module reg_wr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst,
  reg_wr_arbiter_if.slave  bus
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t            state_q;
  logic [2:0]        ptr_q;
  logic [HOLD_W-1:0] hold_q;
  logic [7:0]        gnt_q;
  logic [2:0]        idx_q;
  logic              valid_q;
  logic              timeout_q;

  logic              win_any_d;
  logic [2:0]        win_idx_d;
  logic [2:0]        cand;

  // Scan from ptr_q+7 down to ptr_q so the candidate nearest ptr_q is the last one written.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_any_d = 1'b0;
    win_idx_d = ptr_q;
    cand      = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr_q + 3'(k);
      if (bus.req[cand]) begin
        win_any_d = 1'b1;
        win_idx_d = cand;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      hold_q    <= '0;
      gnt_q     <= 8'd0;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE, GAP: begin
          if (win_any_d) begin
            state_q <= GRANT;
            gnt_q   <= 8'b1 << win_idx_d;
            idx_q   <= win_idx_d;
            valid_q <= 1'b1;
            hold_q  <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          // A voluntary drop wins over the hold limit, so timeout only fires when req is still high.
          if (!bus.req[idx_q] || hold_q == HOLD_LAST) begin
            state_q   <= GAP;
            gnt_q     <= 8'd0;
            valid_q   <= 1'b0;
            ptr_q     <= idx_q + 3'd1;
            timeout_q <= bus.req[idx_q];
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: reset, single grant, fairness, wrap, hold limit,
// full load and asynchronous reset in the middle of a grant.
module tb_reg_wr_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  reg_wr_arbiter_if bus ();

  reg_wr_arbiter #(.MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".gnt"}, 32'(bus.gnt), 32'h0);
    check({tag, ".valid"}, 32'(bus.gnt_valid), 32'h0);
  endtask

  task automatic check_owner(input string tag, input int idx);
    check({tag, ".valid"}, 32'(bus.gnt_valid), 32'h1);
    check({tag, ".idx"}, 32'(bus.gnt_idx), 32'(idx));
    check({tag, ".gnt"}, 32'(bus.gnt), 32'h1 << idx);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_gnt;
    int         order [4];
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    bus.req = 8'h00;

    // Reset state
    do_reset();
    check_idle("rst");
    check("rst.idx", 32'(bus.gnt_idx), 32'h0);
    check("rst.timeout", 32'(bus.timeout), 32'h0);
    tick();
    check_idle("idle_no_req");

    // Single request
    bus.req = 8'h04;
    tick();
    check_owner("single", 2);
    check("single.timeout", 32'(bus.timeout), 32'h0);
    bus.req = 8'h00;
    tick();
    check_idle("single_rel");
    check("single_rel.timeout", 32'(bus.timeout), 32'h0);
    check("single_rel.idx_hold", 32'(bus.gnt_idx), 32'h2);
    tick();
    // ptr is now 3, so requester 3 beats requester 2
    bus.req = 8'h0C;
    tick();
    check_owner("ptr3", 3);
    bus.req = 8'h00;
    tick();
    tick();

    // Fairness with 0 and 7, 3-cycle tenures
    do_reset();
    order   = '{0, 7, 0, 7};
    bus.req = 8'h81;
    for (int t = 0; t < 4; t++) begin
      tick();
      check_owner($sformatf("fair%0d.c1", t), order[t]);
      tick();
      check_owner($sformatf("fair%0d.c2", t), order[t]);
      tick();
      check_owner($sformatf("fair%0d.c3", t), order[t]);
      bus.req = (t == 3) ? 8'h02 : (8'h81 & ~(8'h1 << order[t]));
      tick();
      check_idle($sformatf("fair%0d.gap", t));
      check($sformatf("fair%0d.gap_to", t), 32'(bus.timeout), 32'h0);
      bus.req = (t == 3) ? 8'h82 : 8'h81;
    end

    // Wrap: ptr went 7->0, bit 0 clear, so idx 1 wins over 7
    tick();
    check_owner("wrap", 1);
    bus.req = 8'h00;
    tick();
    tick();

    // Hold limit
    do_reset();
    bus.req = 8'h10;
    tick();
    for (int i = 0; i < 8; i++) begin
      check_owner($sformatf("hold.c%0d", i), 4);
      check($sformatf("hold.c%0d_to", i), 32'(bus.timeout), 32'h0);
      tick();
    end
    check_idle("hold.gap");
    check("hold.timeout", 32'(bus.timeout), 32'h1);
    tick();
    check_owner("hold.regrant", 4);
    check("hold.regrant_to", 32'(bus.timeout), 32'h0);
    // Drop exactly at the hold limit: normal release, no timeout
    for (int i = 0; i < 7; i++) tick();
    check_owner("simul.last", 4);
    bus.req = 8'h00;
    tick();
    check_idle("simul.gap");
    check("simul.timeout", 32'(bus.timeout), 32'h0);
    tick();

    // Full load, 1-cycle tenures
    do_reset();
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      check_owner($sformatf("full%0d", k), k % 8);
      check($sformatf("full%0d.onehot", k), 32'($onehot(bus.gnt)), 32'h1);
      exp_gnt = 8'h1 << (k % 8);
      bus.req = 8'hFF & ~exp_gnt;
      tick();
      check_idle($sformatf("full%0d.gap", k));
      bus.req = 8'hFF;
    end

    // Asynchronous reset while owner 5 is active
    do_reset();
    bus.req = 8'h20;
    tick();
    check_owner("mid.pre", 5);
    #2;
    rst = 1'b1;
    #1;
    check_idle("mid.async");
    check("mid.idx", 32'(bus.gnt_idx), 32'h0);
    check("mid.timeout", 32'(bus.timeout), 32'h0);
    bus.req = 8'hA0;
    tick();
    rst = 1'b0;
    check_idle("mid.held");
    tick();
    check_owner("mid.post", 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Round-robin arbiter that shares the 16-bit CPU's single register-file write port among up to eight requesters (ALU, load unit, PC-link, etc.). It selects one requester at a time, drives the 3-bit destination-select index consumed by the register-file 3-to-8 write decoder, and produces a matching one-hot grant. A forced-release hold limit prevents any one requester from monopolising the port. One idle cycle between grants guarantees the write decoder never sees two back-to-back owners.

## Interface

- MAX_HOLD, 8, maximum consecutive cycles one grant may be held; legal range 2..256
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  8  request vector, bit i = requester i; level-sensitive, held while the requester needs the port
- gnt  output  8  one-hot grant; all-zero when no owner
- gnt_idx  output  3  binary index of current owner; feeds the 3-to-8 write decoder select
- gnt_valid  output  1  high when gnt is non-zero; drives decoder enable and register-file write enable
- timeout  output  1  one-cycle pulse when a grant was force-released by the hold limit

## Operation

- All outputs are registered.
- FSM states: IDLE, GRANT, GAP.
- IDLE: gnt=0, gnt_valid=0. If req != 0 at a rising edge: pick winner, load gnt/gnt_idx, clear hold counter, go to GRANT. Otherwise stay.
- Winner selection: first set bit of req scanning ptr, ptr+1, …, ptr+7, indices modulo 8.
- GRANT: hold counter increments every cycle.
  - req[gnt_idx] low at an edge: release, go to GAP.
  - req[gnt_idx] still high and hold counter = MAX_HOLD-1: release, go to GAP, assert timeout for the GAP cycle.
  - Otherwise hold grant; other req bits are ignored.
- Release actions: gnt=0, gnt_valid=0, ptr = gnt_idx+1 modulo 8 (7 wraps to 0).
- GAP: exactly one cycle with no owner. At the next edge, run the same arbitration as IDLE: go to GRANT if req != 0, else IDLE.
- A timed-out requester that keeps req high is not blocked. It gets lowest priority in the next arbitration because ptr has moved past it.
- gnt_idx holds its last value while gnt_valid=0. Consumers must qualify it with gnt_valid.
- Hold counter width: ceil(log2(MAX_HOLD)) bits, minimum 1. It never wraps because release occurs at MAX_HOLD-1.
- Invariants: gnt is one-hot or zero; gnt_valid == |gnt; gnt == (1 << gnt_idx) whenever gnt_valid.

## Timing

- Reset (asynchronous, any time, including mid-grant): state=IDLE, ptr=0, hold counter=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0. The first edge after rst deasserts may grant.
- Grant latency: req sampled at edge N gives gnt valid after edge N (visible in cycle N+1).
- Release latency: req dropped before edge K removes gnt after edge K. The owner may therefore write in the cycle it drops req.
- Maximum tenure: MAX_HOLD cycles of gnt_valid.
- Minimum spacing between grants: 1 GAP cycle, so a new owner appears at earliest 2 edges after the previous req drop is sampled.
- Worst-case wait for a continuously requesting requester: 7 × (MAX_HOLD+1) cycles.
- Simultaneous events: a req falling in the same cycle the hold limit is reached is treated as a normal release, with timeout=0.

## Test plan

- Single request: req=8'h04 from reset. After 1 edge, gnt=8'h04, gnt_idx=2, gnt_valid=1. Drop req: gnt=0 next edge, timeout=0, ptr=3.
- Two simultaneous, fairness: req=8'h81 held with each owner releasing after 3 cycles. Grant order is 0, 7, 0, 7, with exactly one gnt_valid=0 cycle between tenures.
- Wrap-around: owner 7 releases while req=8'h82. Next grant goes to idx 1, since ptr=0 and bit 0 is clear.
- Hold limit: MAX_HOLD=8, req=8'h10 held high. gnt_valid is high for exactly 8 cycles, then 1 cycle with gnt=0 and timeout=1, then bit 4 is re-granted.
- Full load: req=8'hFF with each owner releasing after 1 cycle. Grants cycle 0→1→…→7→0. Checker confirms one-hot, gnt==1<<gnt_idx, and no idx is repeated within 8 grants.
- Reset mid-grant: assert rst while owner 5 is active. All outputs go to 0 immediately, without waiting for an edge. After deassertion with req=8'hA0, the grant goes to idx 5 because ptr=0.
